// File: rtl/i2c_txn_seq.sv
// Register-level I2C transaction sequencer: turns a start/rw request into the
// byte-command sequence of a write or a repeated-start read, with NACK and timeout handling.
module i2c_txn_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] i2c_slave_addr,
   input  logic [8:0] i2c_addr,
   input  logic [7:0] reg_file_to_i2c_data,
   output logic       byte_req,
   output logic [1:0] byte_cmd,
   output logic [7:0] byte_tx,
   input  logic       byte_done,
   input  logic       byte_nack,
   input  logic [7:0] byte_rx,
   output logic       byte_abort,
   output logic       i2c_wr_en,
   output logic [1:0] i2c_sts,
   output logic [7:0] i2c_to_reg_file_data,
   output logic       busy
);

   localparam int unsigned TMR_W = 16;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] CMD_START_WR = 2'b00;
   localparam logic [1:0] CMD_WR       = 2'b01;
   localparam logic [1:0] CMD_RD_NACK  = 2'b10;
   localparam logic [1:0] CMD_STOP     = 2'b11;

   localparam logic [1:0] STS_OK      = 2'b00;
   localparam logic [1:0] STS_BUSY    = 2'b01;
   localparam logic [1:0] STS_NACK    = 2'b10;
   localparam logic [1:0] STS_TIMEOUT = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE, S_SLA_W, S_ADDR_HI, S_ADDR_LO, S_DATA_W, S_SLA_R, S_DATA_R, S_STOP, S_DONE
   } state_t;

   state_t           r_state, w_state_n, w_next_ok;
   logic             r_byte_req, w_byte_req_n;
   logic [1:0]       r_cmd, w_cmd_n;
   logic [7:0]       r_tx, w_tx_n;
   logic             r_abort, w_abort_n;
   logic             r_wr_en, w_wr_en_n;
   logic [1:0]       r_sts, w_sts_n;
   logic [7:0]       r_rd_data, w_rd_data_n;
   logic             r_busy, w_busy_n;
   logic [TMR_W-1:0] r_timer, w_timer_n;
   logic             r_nack, w_nack_n;
   logic [7:0]       r_rx_hold, w_rx_hold_n;
   logic             r_rw, w_rw_n;
   logic [6:0]       r_sla, w_sla_n;
   logic [8:0]       r_addr, w_addr_n;
   logic [7:0]       r_wdata, w_wdata_n;
   logic             w_is_byte, w_nackable;
   logic             w_done, w_timeout;
   logic             w_unused_sla_msb;

   assign w_unused_sla_msb = i2c_slave_addr[7];

   // Completion only counts while a request is outstanding; done beats timeout.
   assign w_done    = r_byte_req & byte_done;
   assign w_timeout = r_byte_req & ~byte_done & (r_timer == TMR_LAST);

   assign byte_req             = r_byte_req;
   assign byte_cmd             = r_cmd;
   assign byte_tx              = r_tx;
   assign byte_abort           = r_abort;
   assign i2c_wr_en            = r_wr_en;
   assign i2c_sts              = r_sts;
   assign i2c_to_reg_file_data = r_rd_data;
   assign busy                 = r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_byte_req <= 1'b0;
         r_cmd      <= 2'b00;
         r_tx       <= 8'h00;
         r_abort    <= 1'b0;
         r_wr_en    <= 1'b0;
         r_sts      <= 2'b00;
         r_rd_data  <= 8'h00;
         r_busy     <= 1'b0;
         r_timer    <= '0;
         r_nack     <= 1'b0;
         r_rx_hold  <= 8'h00;
         r_rw       <= 1'b0;
         r_sla      <= 7'h00;
         r_addr     <= 9'h000;
         r_wdata    <= 8'h00;
      end else begin
         r_state    <= w_state_n;
         r_byte_req <= w_byte_req_n;
         r_cmd      <= w_cmd_n;
         r_tx       <= w_tx_n;
         r_abort    <= w_abort_n;
         r_wr_en    <= w_wr_en_n;
         r_sts      <= w_sts_n;
         r_rd_data  <= w_rd_data_n;
         r_busy     <= w_busy_n;
         r_timer    <= w_timer_n;
         r_nack     <= w_nack_n;
         r_rx_hold  <= w_rx_hold_n;
         r_rw       <= w_rw_n;
         r_sla      <= w_sla_n;
         r_addr     <= w_addr_n;
         r_wdata    <= w_wdata_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_next_ok   = r_state;
      w_is_byte   = 1'b0;
      w_nackable  = 1'b0;
      w_abort_n   = 1'b0;
      w_wr_en_n   = 1'b0;
      w_sts_n     = r_sts;
      w_rd_data_n = r_rd_data;
      w_nack_n    = r_nack;
      w_rx_hold_n = r_rx_hold;
      w_rw_n      = r_rw;
      w_sla_n     = r_sla;
      w_addr_n    = r_addr;
      w_wdata_n   = r_wdata;
      w_cmd_n     = r_cmd;
      w_tx_n      = r_tx;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_rw_n    = rw;
               w_sla_n   = i2c_slave_addr[6:0];
               w_addr_n  = i2c_addr;
               w_wdata_n = reg_file_to_i2c_data;
               w_nack_n  = 1'b0;
               w_wr_en_n = 1'b1;
               w_sts_n   = STS_BUSY;
               w_state_n = S_SLA_W;
            end
         end
         S_SLA_W: begin
            w_is_byte = 1'b1; w_nackable = 1'b1; w_next_ok = S_ADDR_HI;
            w_cmd_n = CMD_START_WR; w_tx_n = {r_sla, 1'b0};
         end
         S_ADDR_HI: begin
            w_is_byte = 1'b1; w_nackable = 1'b1; w_next_ok = S_ADDR_LO;
            w_cmd_n = CMD_WR; w_tx_n = {7'b0, r_addr[8]};
         end
         S_ADDR_LO: begin
            w_is_byte = 1'b1; w_nackable = 1'b1; w_next_ok = r_rw ? S_SLA_R : S_DATA_W;
            w_cmd_n = CMD_WR; w_tx_n = r_addr[7:0];
         end
         S_DATA_W: begin
            w_is_byte = 1'b1; w_nackable = 1'b1; w_next_ok = S_STOP;
            w_cmd_n = CMD_WR; w_tx_n = r_wdata;
         end
         S_SLA_R: begin
            w_is_byte = 1'b1; w_nackable = 1'b1; w_next_ok = S_DATA_R;
            w_cmd_n = CMD_START_WR; w_tx_n = {r_sla, 1'b1};
         end
         S_DATA_R: begin
            w_is_byte = 1'b1;
            w_cmd_n = CMD_RD_NACK; w_tx_n = 8'h00;
            if (w_done) begin
               w_rx_hold_n = byte_rx;
               w_state_n   = S_STOP;
            end
         end
         S_STOP: begin
            w_is_byte = 1'b1;
            w_cmd_n = CMD_STOP; w_tx_n = 8'h00;
            if (w_done) begin
               w_wr_en_n = 1'b1;
               w_sts_n   = r_nack ? STS_NACK : STS_OK;
               if (!r_nack && r_rw) w_rd_data_n = r_rx_hold;
               w_state_n = S_DONE;
            end
         end
         S_DONE:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase

      // Address/data phases: ACK advances, NACK jumps to STOP with the error flagged.
      if (w_nackable && w_done) begin
         if (byte_nack) begin
            w_nack_n  = 1'b1;
            w_state_n = S_STOP;
         end else begin
            w_state_n = w_next_ok;
         end
      end

      // Timeout abandons the bus without STOP and overrides any pending NACK status.
      if (w_timeout) begin
         w_abort_n = 1'b1;
         w_wr_en_n = 1'b1;
         w_sts_n   = STS_TIMEOUT;
         w_state_n = S_IDLE;
      end

      w_byte_req_n = w_is_byte && (w_state_n == r_state);
      w_timer_n    = (w_state_n != r_state) ? '0 :
                     (r_byte_req ? r_timer + TMR_W'(1) : r_timer);
      w_busy_n     = (w_state_n != S_IDLE);
   end

endmodule

// File: tb/tb_i2c_txn_seq.sv
// Directed bench for i2c_txn_seq: a byte-master responder checks each request
// against a queue of expected bytes, and a monitor checks every status strobe.
module tb_i2c_txn_seq;

   localparam int unsigned TMO = 16;

   logic       clk = 1'b0;
   logic       rst, start, rw;
   logic [7:0] sla;
   logic [8:0] addr;
   logic [7:0] wdata;
   logic       byte_req;
   logic [1:0] byte_cmd;
   logic [7:0] byte_tx;
   logic       byte_done, byte_nack;
   logic [7:0] byte_rx;
   logic       byte_abort, i2c_wr_en;
   logic [1:0] i2c_sts;
   logic [7:0] rd_data;
   logic       busy;

   typedef struct packed { logic [1:0] cmd; logic [7:0] tx; logic chk; } op_t;
   typedef struct packed { logic [1:0] sts; logic [7:0] data; } sts_t;

   op_t  q_byte[$];
   sts_t q_sts[$];
   sts_t mon_s;

   int n_pass = 0, n_total = 0, n_fail = 0;
   int n_abort_seen = 0, exp_aborts = 0;
   logic [7:0] exp_data;

   i2c_txn_seq #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw),
      .i2c_slave_addr(sla), .i2c_addr(addr), .reg_file_to_i2c_data(wdata),
      .byte_req(byte_req), .byte_cmd(byte_cmd), .byte_tx(byte_tx),
      .byte_done(byte_done), .byte_nack(byte_nack), .byte_rx(byte_rx),
      .byte_abort(byte_abort), .i2c_wr_en(i2c_wr_en), .i2c_sts(i2c_sts),
      .i2c_to_reg_file_data(rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (failure #%0d)", tag, obs, exp, n_fail);
      end
   endtask

   // Every status strobe must match the next scoreboard entry.
   always @(negedge clk) begin
      if (i2c_wr_en === 1'b1) begin
         if (q_sts.size() == 0) check("unexpected_wr_en", 16'(1), 16'(0));
         else begin
            mon_s = q_sts.pop_front();
            check("strobe_sts", 16'(i2c_sts), 16'(mon_s.sts));
            check("strobe_data", 16'(rd_data), 16'(mon_s.data));
         end
      end
      if (byte_abort === 1'b1) n_abort_seen++;
   end

   task automatic push_op(input logic [1:0] c, input logic [7:0] t, input logic chk);
      op_t o;
      o.cmd = c; o.tx = t; o.chk = chk;
      q_byte.push_back(o);
   endtask

   task automatic push_sts(input logic [1:0] s, input logic [7:0] d);
      sts_t e;
      e.sts = s; e.data = d;
      q_sts.push_back(e);
   endtask

   task automatic start_txn(input logic r, input logic [7:0] s, input logic [8:0] a, input logic [7:0] d);
      push_sts(2'b01, exp_data);
      rw = r; sla = s; addr = a; wdata = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 16'(busy), 16'(1));
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      op_t e;
      while (byte_req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_req"}, 16'(byte_req), 16'(1));
      if (q_byte.size() == 0) check({tag, "_unexpected_op"}, 16'(1), 16'(0));
      else begin
         e = q_byte.pop_front();
         check({tag, "_cmd"}, 16'(byte_cmd), 16'(e.cmd));
         if (e.chk) check({tag, "_tx"}, 16'(byte_tx), 16'(e.tx));
      end
   endtask

   task automatic serve_byte(input string tag, input logic nack, input logic [7:0] rx, input int dly);
      logic [1:0] c0;
      logic [7:0] t0;
      logic ok;
      wait_req(tag);
      c0 = byte_cmd; t0 = byte_tx; ok = 1'b1;
      repeat (dly) begin
         @(negedge clk);
         if (byte_req !== 1'b1 || byte_cmd !== c0 || byte_tx !== t0) ok = 1'b0;
      end
      byte_done = 1'b1; byte_nack = nack; byte_rx = rx;
      @(negedge clk);
      byte_done = 1'b0; byte_nack = 1'b0; byte_rx = 8'h00;
      if (dly > 0) check({tag, "_stable"}, 16'(ok), 16'(1));
      check({tag, "_drop"}, 16'(byte_req), 16'(0));
   endtask

   task automatic expect_timeout(input string tag);
      int k = 0;
      push_sts(2'b11, exp_data);
      wait_req(tag);
      while (byte_abort !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      exp_aborts++;
      check({tag, "_cycles"}, 16'(k), 16'(TMO));
      check({tag, "_req_low"}, 16'(byte_req), 16'(0));
      check({tag, "_busy"}, 16'(busy), 16'(0));
      @(negedge clk);
      check({tag, "_abort_pulse"}, 16'(byte_abort), 16'(0));
      check({tag, "_sts_hold"}, 16'(i2c_sts), 16'(2'b11));
      check({tag, "_busy_hold"}, 16'(busy), 16'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_byte_req"}, 16'(byte_req), 16'(0));
      check({tag, "_byte_cmd"}, 16'(byte_cmd), 16'(0));
      check({tag, "_byte_tx"}, 16'(byte_tx), 16'(0));
      check({tag, "_abort"}, 16'(byte_abort), 16'(0));
      check({tag, "_wr_en"}, 16'(i2c_wr_en), 16'(0));
      check({tag, "_sts"}, 16'(i2c_sts), 16'(0));
      check({tag, "_rd_data"}, 16'(rd_data), 16'(0));
      check({tag, "_busy"}, 16'(busy), 16'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rw = 1'b0; sla = 8'h00; addr = 9'h000; wdata = 8'h00;
      byte_done = 1'b0; byte_nack = 1'b0; byte_rx = 8'h00; exp_data = 8'h00;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Write, all ACK; bit 7 of the slave address is ignored
      push_op(2'b00, 8'hA0, 1'b1); push_op(2'b01, 8'h01, 1'b1);
      push_op(2'b01, 8'hA3, 1'b1); push_op(2'b01, 8'h5C, 1'b1); push_op(2'b11, 8'h00, 1'b0);
      start_txn(1'b0, 8'hD0, 9'h1A3, 8'h5C);
      push_sts(2'b00, exp_data);
      serve_byte("w_sla", 1'b0, 8'h00, 0);
      serve_byte("w_ahi", 1'b0, 8'h00, 2);
      serve_byte("w_alo", 1'b0, 8'h00, 1);
      serve_byte("w_data", 1'b0, 8'h00, 3);
      serve_byte("w_stop", 1'b0, 8'h00, 0);
      @(negedge clk);
      check("w_idle_busy", 16'(busy), 16'(0));

      // Read with a stray start mid-transaction and a NACK on the read byte
      push_op(2'b00, 8'hA0, 1'b1); push_op(2'b01, 8'h00, 1'b1); push_op(2'b01, 8'h04, 1'b1);
      push_op(2'b00, 8'hA1, 1'b1); push_op(2'b10, 8'h00, 1'b0); push_op(2'b11, 8'h00, 1'b0);
      start_txn(1'b1, 8'h50, 9'h004, 8'h77);
      push_sts(2'b00, 8'h9E);
      serve_byte("r_sla", 1'b0, 8'h00, 1);
      rw = 1'b0; sla = 8'h12; addr = 9'h0AB; wdata = 8'hEE; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("r_stray_start_busy", 16'(busy), 16'(1));
      serve_byte("r_ahi", 1'b0, 8'h00, 0);
      serve_byte("r_alo", 1'b0, 8'h00, 2);
      serve_byte("r_slar", 1'b0, 8'h00, 0);
      serve_byte("r_data", 1'b1, 8'h9E, 4);
      serve_byte("r_stop", 1'b0, 8'h00, 1);
      @(negedge clk);
      exp_data = 8'h9E;
      check("r_rd_data", 16'(rd_data), 16'(8'h9E));
      check("r_idle_busy", 16'(busy), 16'(0));

      // NACK on the low address byte skips the data byte
      push_op(2'b00, 8'h54, 1'b1); push_op(2'b01, 8'h00, 1'b1);
      push_op(2'b01, 8'hFF, 1'b1); push_op(2'b11, 8'h00, 1'b0);
      start_txn(1'b0, 8'h2A, 9'h0FF, 8'h11);
      push_sts(2'b10, exp_data);
      serve_byte("n_sla", 1'b0, 8'h00, 0);
      serve_byte("n_ahi", 1'b0, 8'h00, 0);
      serve_byte("n_alo", 1'b1, 8'h00, 2);
      serve_byte("n_stop", 1'b0, 8'h00, 0);
      @(negedge clk);
      check("n_rd_data_kept", 16'(rd_data), 16'(8'h9E));

      // byte_done while idle has no effect
      byte_done = 1'b1; byte_nack = 1'b1;
      @(negedge clk);
      byte_done = 1'b0; byte_nack = 1'b0;
      check("idle_done_busy", 16'(busy), 16'(0));
      check("idle_done_req", 16'(byte_req), 16'(0));

      // Master never answers the first byte
      push_op(2'b00, 8'hA0, 1'b1);
      start_txn(1'b0, 8'h50, 9'h1A3, 8'h5C);
      expect_timeout("tmo_sla");

      // Completion on the last timer cycle beats the timeout
      push_op(2'b00, 8'hA0, 1'b1); push_op(2'b01, 8'h01, 1'b1);
      push_op(2'b01, 8'hA3, 1'b1); push_op(2'b01, 8'h5C, 1'b1); push_op(2'b11, 8'h00, 1'b0);
      start_txn(1'b0, 8'h50, 9'h1A3, 8'h5C);
      push_sts(2'b00, exp_data);
      serve_byte("e_sla", 1'b0, 8'h00, TMO - 1);
      serve_byte("e_ahi", 1'b0, 8'h00, 0);
      serve_byte("e_alo", 1'b0, 8'h00, 0);
      serve_byte("e_data", 1'b0, 8'h00, 0);
      serve_byte("e_stop", 1'b0, 8'h00, TMO - 1);
      @(negedge clk);
      check("edge_no_abort", 16'(n_abort_seen), 16'(exp_aborts));

      // NACK then a stalled STOP: timeout status wins over NACK
      push_op(2'b00, 8'hA0, 1'b1); push_op(2'b11, 8'h00, 1'b0);
      start_txn(1'b1, 8'h50, 9'h004, 8'h00);
      serve_byte("s_sla", 1'b1, 8'h00, 0);
      expect_timeout("tmo_stop");
      check("s_rd_data_kept", 16'(rd_data), 16'(8'h9E));

      // Reset while the data byte is outstanding
      push_op(2'b00, 8'h78, 1'b1); push_op(2'b01, 8'h01, 1'b1);
      push_op(2'b01, 8'h00, 1'b1); push_op(2'b01, 8'hA5, 1'b1);
      start_txn(1'b0, 8'h3C, 9'h100, 8'hA5);
      serve_byte("x_sla", 1'b0, 8'h00, 0);
      serve_byte("x_ahi", 1'b0, 8'h00, 0);
      serve_byte("x_alo", 1'b0, 8'h00, 0);
      wait_req("x_data");
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midrst");
      exp_data = 8'h00;
      rst = 1'b0;
      @(negedge clk);

      // Normal write after the mid-transaction reset
      push_op(2'b00, 8'hA0, 1'b1); push_op(2'b01, 8'h01, 1'b1);
      push_op(2'b01, 8'hA3, 1'b1); push_op(2'b01, 8'h5C, 1'b1); push_op(2'b11, 8'h00, 1'b0);
      start_txn(1'b0, 8'h50, 9'h1A3, 8'h5C);
      push_sts(2'b00, exp_data);
      serve_byte("p_sla", 1'b0, 8'h00, 0);
      serve_byte("p_ahi", 1'b0, 8'h00, 0);
      serve_byte("p_alo", 1'b0, 8'h00, 0);
      serve_byte("p_data", 1'b0, 8'h00, 0);
      serve_byte("p_stop", 1'b0, 8'h00, 0);
      @(negedge clk);
      check("p_idle_busy", 16'(busy), 16'(0));

      repeat (2) @(negedge clk);
      check("byte_queue_drained", 16'(q_byte.size()), 16'(0));
      check("sts_queue_drained", 16'(q_sts.size()), 16'(0));
      check("abort_count", 16'(n_abort_seen), 16'(exp_aborts));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/i2c_txn_seq.md
I2C_TXN_SEQ -- requirements
Module: i2c_txn_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the maximum number of clk cycles allowed per byte operation before the transaction aborts.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a transaction.
REQ-005 rw  input  1  transaction type: 0 = register write, 1 = register read; sampled with start.
REQ-006 i2c_slave_addr  input  8  target device; bits [6:0] are the 7-bit address, bit 7 is ignored.
REQ-007 i2c_addr  input  9  target register address inside the device.
REQ-008 reg_file_to_i2c_data  input  8  write payload.
REQ-009 byte_req  output  1  request to the byte-level I2C master; held until byte_done.
REQ-010 byte_cmd  output  2  byte command: 00 START+WRITE, 01 WRITE, 10 READ+NACK, 11 STOP.
REQ-011 byte_tx  output  8  byte to transmit.
REQ-012 byte_done  input  1  one-cycle completion pulse from the master.
REQ-013 byte_nack  input  1  valid with byte_done; 1 = the slave NACKed.
REQ-014 byte_rx  input  8  received byte; valid with byte_done on a READ.
REQ-015 byte_abort  output  1  one-cycle pulse forcing the master to idle.
REQ-016 i2c_wr_en  output  1  one-cycle strobe that updates the register-file status and read data.
REQ-017 i2c_sts  output  2  status: 00 OK, 01 BUSY, 10 NACK error, 11 TIMEOUT.
REQ-018 i2c_to_reg_file_data  output  8  last byte read.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 The FSM states SHALL be IDLE, SLA_W, ADDR_HI, ADDR_LO, DATA_W, SLA_R, DATA_R, STOP, DONE.
REQ-021 In IDLE, start=1 SHALL do all of the following in the same edge:
- latch rw, i2c_slave_addr[6:0], i2c_addr and reg_file_to_i2c_data;
- move to SLA_W;
- pulse i2c_wr_en with i2c_sts=01.
REQ-022 start while busy=1 SHALL be ignored, and the latched operands SHALL NOT change.
REQ-023 Per-state command and byte SHALL be:
- SLA_W: cmd 00, tx {addr7,0};
- ADDR_HI: cmd 01, tx {7'b0,addr[8]};
- ADDR_LO: cmd 01, tx addr[7:0];
- DATA_W: cmd 01, tx data;
- SLA_R: cmd 00, tx {addr7,1}, which is a repeated start;
- DATA_R: cmd 10;
- STOP: cmd 11.
REQ-024 byte_req SHALL rise the cycle after entry into a byte state and stay high, with byte_cmd and byte_tx stable, until the cycle byte_done is sampled high.
- byte_req SHALL drop in the cycle after byte_done.
REQ-025 State transitions on byte_done with byte_nack=0 SHALL be:
- SLA_W to ADDR_HI, then ADDR_HI to ADDR_LO;
- from ADDR_LO: rw=0 goes to DATA_W, rw=1 goes to SLA_R;
- DATA_W to STOP; SLA_R to DATA_R; DATA_R to STOP; STOP to DONE.
REQ-026 In DATA_R, on byte_done, byte_rx SHALL be captured into an internal holding register, and byte_nack SHALL be ignored.
REQ-027 byte_done with byte_nack=1 in SLA_W, ADDR_HI, ADDR_LO, DATA_W or SLA_R SHALL record a NACK error flag and go to STOP.
REQ-028 DONE SHALL last one cycle, pulse i2c_wr_en, and return to IDLE.
- i2c_sts SHALL be 10 if the NACK flag is set, else 00.
- i2c_to_reg_file_data SHALL take the holding register on read success; otherwise it keeps its previous value.
REQ-029 A 16-bit per-byte timer SHALL clear on every state entry and increment while byte_req=1.
REQ-030 When the timer reaches TIMEOUT_CYCLES-1 without byte_done, the next edge SHALL do all of the following:
- pulse byte_abort;
- drop byte_req;
- pulse i2c_wr_en with i2c_sts=11;
- go directly to IDLE, with no STOP issued.
REQ-031 If byte_done and the timeout occur in the same cycle, byte_done SHALL win.
REQ-032 A TIMEOUT in the STOP state SHALL report 11 and override any NACK flag.
REQ-033 i2c_sts SHALL hold its last value between i2c_wr_en strobes.
REQ-034 byte_done seen in IDLE or DONE SHALL be ignored.
REQ-035 Total latency for a write SHALL be 5 byte operations plus 2 cycles; for a read, 6 byte operations plus 2 cycles.

Reset
REQ-036 rst=1 SHALL force the FSM to IDLE, clear the timer and the NACK flag, and drive byte_req, byte_abort, i2c_wr_en and busy to 0.
REQ-037 rst=1 SHALL drive byte_cmd, byte_tx, i2c_sts and i2c_to_reg_file_data to 0.
REQ-038 rst asserted mid-transaction SHALL abandon it with no status strobe; the master is reset by the same rst.

Verification
REQ-039 Write, addr7=0x50, i2c_addr=0x1A3, data=0x5C, all ACK:
- bytes are A0(cmd00), 01, A3, 5C, then STOP;
- i2c_wr_en strobes twice, with sts 01 and then 00.
REQ-040 Read, addr7=0x50, i2c_addr=0x004, byte_rx=0x9E:
- bytes are A0, 00, 04, A1(cmd00), READ(cmd10), then STOP;
- final sts=00 and i2c_to_reg_file_data=0x9E.
REQ-041 NACK on ADDR_LO:
- STOP is issued next and there is no DATA_W;
- final sts=10 and i2c_to_reg_file_data is unchanged.
REQ-042 TIMEOUT_CYCLES=16 with byte_done withheld in SLA_W:
- byte_abort pulses 16 cycles after byte_req rises;
- sts=11 and busy=0 on the next cycle.
REQ-043 start pulsed during an active read:
- it is ignored, and the transaction completes with the originally latched operands.
REQ-044 rst pulsed during DATA_W:
- all outputs are 0 on the next cycle, with no i2c_wr_en strobe;
- a new start afterwards runs normally.
